cam_tag_sequencer: RTL and testbench

Command front-end placed directly upstream of the tag CAM (`cam_tag`, same N/DEPTH). It accepts tag-allocate and tag-release requests on two valid/ready channels and arbitrates them round-robin. It issues at most one CAM operation per cycle, using the CAM's match status to screen out duplicate allocations and releases of unknown tags, and reports each completed operation.

---
 rtl/cam_tag_pkg.sv | 16 +
 rtl/cam_tag.sv | 57 +++++
 rtl/cam_tag_sequencer.sv | 156 +++++++++++++++
 tb/tb_cam_tag_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cam_tag_pkg.sv
// Shared types for the tag CAM and its command front-end.
// Holds the operation encoding and default geometry.
// No logic; imported by the CAM and the sequencer.
package cam_tag_pkg;

    // Default geometry; instantiations normally override these.
    localparam int TAG_W_DEF = 8;
    localparam int DEPTH_DEF = 16;

    // Operation encoding shared by the command register and the done report.
    typedef enum logic {
        OP_ALLOC   = 1'b0,
        OP_RELEASE = 1'b1
    } cam_op_t;

endpackage : cam_tag_pkg

// File: rtl/cam_tag.sv
// Tag CAM: DEPTH entries of N-bit tags with a valid bit each.
// Lookup is combinational on i_tag_in; mark writes land on the next edge.
// No backpressure; the caller guarantees marks are legal.
module cam_tag #(
    parameter int N     = 8,
    parameter int DEPTH = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [N-1:0] i_tag_in,
    input  logic         i_mark_valid,
    input  logic         i_mark_invalid,
    output logic         ow_tag_status,
    output logic         ow_tags_full
);

    logic [DEPTH-1:0] vld_q;
    logic [N-1:0]     tag_q [DEPTH];
    logic [DEPTH-1:0] match;
    logic [DEPTH-1:0] free_oh;
    logic             free_found;

    // Per-entry match against the lookup tag, and lowest free slot as one-hot.
    always_comb begin
        match      = '0;
        free_oh    = '0;
        free_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = vld_q[i] && (tag_q[i] == i_tag_in);
            if (!vld_q[i] && !free_found) begin
                free_oh[i] = 1'b1;
                free_found = 1'b1;
            end
        end
    end

    assign ow_tag_status = |match;
    assign ow_tags_full  = &vld_q;

    // Insert into the lowest free slot, or clear every matching slot.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) tag_q[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_mark_valid && free_oh[i]) begin
                    vld_q[i] <= 1'b1;
                    tag_q[i] <= i_tag_in;
                end else if (i_mark_invalid && match[i]) begin
                    vld_q[i] <= 1'b0;
                end
            end
        end
    end

endmodule : cam_tag

// File: rtl/cam_tag_sequencer.sv
// Round-robin alloc/release front-end issuing one screened CAM op per cycle.
// Handshake-to-done latency 2 cycles; one op per cycle throughput.
// Alloc ready drops when count plus pending alloc reaches DEPTH; release never blocked by full.
module cam_tag_sequencer
    import cam_tag_pkg::*;
#(
    parameter int N     = 8,
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_alloc_valid,
    output logic          o_alloc_ready,
    input  logic [N-1:0]  i_alloc_tag,
    input  logic          i_rel_valid,
    output logic          o_rel_ready,
    input  logic [N-1:0]  i_rel_tag,
    output logic [N-1:0]  o_cam_tag,
    output logic          o_cam_mark_valid,
    output logic          o_cam_mark_invalid,
    input  logic          i_cam_tag_status,
    input  logic          i_cam_full,
    output logic          o_done_valid,
    output logic          o_done_op,
    output logic [N-1:0]  o_done_tag,
    output logic          o_done_err,
    output logic [CW-1:0] o_count,
    output logic          o_err_sticky
);

    typedef struct packed {
        cam_op_t      op;
        logic [N-1:0] tag;
    } cmd_t;

    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    // Command register (stage A output / stage B input)
    logic    cmd_vld_q, cmd_vld_d;
    cmd_t    cmd_q, cmd_d;
    cam_op_t last_op_q, last_op_d;

    // Occupancy and status
    logic [CW-1:0] count_q, count_d;
    logic          sticky_q, sticky_d;

    // Completion report
    logic          done_vld_q, done_vld_d;
    cam_op_t       done_op_q, done_op_d;
    logic [N-1:0]  done_tag_q, done_tag_d;
    logic          done_err_q, done_err_d;

    logic          pend_alloc;
    logic [CW:0]   occ;
    logic          space;
    logic          alloc_elig;
    logic          grant_alloc;
    logic          grant_rel;
    logic          count_full;
    logic          mark_vld;
    logic          mark_inv;
    logic          reject;

    assign pend_alloc = cmd_vld_q && (cmd_q.op == OP_ALLOC);
    assign occ        = {1'b0, count_q} + (CW + 1)'(pend_alloc);
    assign space      = occ < DEPTH_W;
    assign alloc_elig = i_alloc_valid && space;
    assign count_full = (count_q == DEPTH_W[CW-1:0]);

    // Two-way round-robin: on conflict the op not granted last wins.
    always_comb begin
        grant_alloc = alloc_elig;
        if (alloc_elig && i_rel_valid) grant_alloc = (last_op_q == OP_RELEASE);
        grant_rel = i_rel_valid && !grant_alloc;
    end

    // Readies mirror the grant but each looks only at the other channel's valid.
    // Held low during reset so every output reads 0 while i_rst_n is asserted.
    assign o_alloc_ready = i_rst_n && space && !(i_rel_valid && (last_op_q == OP_ALLOC));
    assign o_rel_ready   = i_rst_n && !(alloc_elig && (last_op_q == OP_RELEASE));

    // Stage B: screen the pending command with the CAM's live match status.
    always_comb begin
        mark_vld = 1'b0;
        mark_inv = 1'b0;
        reject   = 1'b0;
        if (cmd_vld_q) begin
            if (cmd_q.op == OP_ALLOC) begin
                mark_vld = !i_cam_tag_status && !count_full;
                reject   = !mark_vld;
            end else begin
                mark_inv = i_cam_tag_status;
                reject   = !i_cam_tag_status;
            end
        end
    end

    assign o_cam_tag          = cmd_vld_q ? cmd_q.tag : '0;
    assign o_cam_mark_valid   = mark_vld;
    assign o_cam_mark_invalid = mark_inv;

    // Next-state: accept a new command, update count/sticky, capture completion.
    always_comb begin
        cmd_vld_d = grant_alloc || grant_rel;
        cmd_d     = grant_rel ? cmd_t'{op: OP_RELEASE, tag: i_rel_tag}
                              : cmd_t'{op: OP_ALLOC,   tag: i_alloc_tag};
        last_op_d = last_op_q;
        if (grant_alloc) last_op_d = OP_ALLOC;
        else if (grant_rel) last_op_d = OP_RELEASE;

        count_d = count_q;
        if (mark_vld)      count_d = count_q + 1'b1;
        else if (mark_inv) count_d = count_q - 1'b1;

        sticky_d = sticky_q || reject || (i_cam_full != count_full);

        done_vld_d = cmd_vld_q;
        done_op_d  = cmd_q.op;
        done_tag_d = cmd_q.tag;
        done_err_d = reject;
    end

    // State registers; reset discards any pending command without a done pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cmd_vld_q  <= 1'b0;
            cmd_q      <= cmd_t'{op: OP_ALLOC, tag: '0};
            last_op_q  <= OP_RELEASE;
            count_q    <= '0;
            sticky_q   <= 1'b0;
            done_vld_q <= 1'b0;
            done_op_q  <= OP_ALLOC;
            done_tag_q <= '0;
            done_err_q <= 1'b0;
        end else begin
            cmd_vld_q  <= cmd_vld_d;
            cmd_q      <= cmd_d;
            last_op_q  <= last_op_d;
            count_q    <= count_d;
            sticky_q   <= sticky_d;
            done_vld_q <= done_vld_d;
            done_op_q  <= done_op_d;
            done_tag_q <= done_tag_d;
            done_err_q <= done_err_d;
        end
    end

    assign o_done_valid = done_vld_q;
    assign o_done_op    = done_op_q;
    assign o_done_tag   = done_tag_q;
    assign o_done_err   = done_err_q;
    assign o_count      = count_q;
    assign o_err_sticky = sticky_q;

endmodule : cam_tag_sequencer

// File: tb/tb_cam_tag_sequencer.sv
// Directed bench: cam_tag_sequencer driving a real cam_tag (DEPTH=4 for a reachable full boundary).
// Inputs change 1ns after the rising edge; outputs are checked mid-cycle.
module tb_cam_tag_sequencer;
    import cam_tag_pkg::*;

    localparam int N     = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          alloc_valid = 1'b0;
    logic          alloc_ready;
    logic [N-1:0]  alloc_tag = '0;
    logic          rel_valid = 1'b0;
    logic          rel_ready;
    logic [N-1:0]  rel_tag = '0;
    logic [N-1:0]  cam_tag_w;
    logic          mark_valid, mark_invalid;
    logic          tag_status, tags_full;
    logic          done_valid, done_op, done_err;
    logic [N-1:0]  done_tag;
    logic [CW-1:0] count;
    logic          err_sticky;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cam_tag_sequencer #(.N(N), .DEPTH(DEPTH)) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_alloc_valid      (alloc_valid),
        .o_alloc_ready      (alloc_ready),
        .i_alloc_tag        (alloc_tag),
        .i_rel_valid        (rel_valid),
        .o_rel_ready        (rel_ready),
        .i_rel_tag          (rel_tag),
        .o_cam_tag          (cam_tag_w),
        .o_cam_mark_valid   (mark_valid),
        .o_cam_mark_invalid (mark_invalid),
        .i_cam_tag_status   (tag_status),
        .i_cam_full         (tags_full),
        .o_done_valid       (done_valid),
        .o_done_op          (done_op),
        .o_done_tag         (done_tag),
        .o_done_err         (done_err),
        .o_count            (count),
        .o_err_sticky       (err_sticky)
    );

    cam_tag #(.N(N), .DEPTH(DEPTH)) u_cam (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_tag_in       (cam_tag_w),
        .i_mark_valid   (mark_valid),
        .i_mark_invalid (mark_invalid),
        .ow_tag_status  (tag_status),
        .ow_tags_full   (tags_full)
    );

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Advance one cycle; returns 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        alloc_valid = 1'b0;
        rel_valid   = 1'b0;
        rst_n       = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst_n = 1'b0;
        #3;
        check_eq("rst_done_valid", done_valid, 0);
        check_eq("rst_count", count, 0);
        check_eq("rst_sticky", err_sticky, 0);
        check_eq("rst_alloc_ready", alloc_ready, 0);
        check_eq("rst_rel_ready", rel_ready, 0);
        check_eq("rst_cam_tag", cam_tag_w, 0);
        check_eq("rst_marks", {mark_valid, mark_invalid}, 0);
        do_reset();

        // Single alloc: mark on cycle 1, done on cycle 2
        alloc_valid = 1'b1; alloc_tag = 8'h05;
        #1 check_eq("t1_alloc_ready", alloc_ready, 1);
        tick();
        alloc_valid = 1'b0;
        #1;
        check_eq("t1_mark_valid", mark_valid, 1);
        check_eq("t1_cam_tag", cam_tag_w, 8'h05);
        check_eq("t1_no_done_yet", done_valid, 0);
        tick();
        check_eq("t1_done_valid", done_valid, 1);
        check_eq("t1_done_op", done_op, 0);
        check_eq("t1_done_err", done_err, 0);
        check_eq("t1_done_tag", done_tag, 8'h05);
        check_eq("t1_count", count, 1);
        tick();
        check_eq("t1_done_pulse_end", done_valid, 0);
        check_eq("t1_sticky", err_sticky, 0);

        // Back-to-back duplicate alloc
        do_reset();
        alloc_valid = 1'b1; alloc_tag = 8'h05;
        tick();
        tick();
        alloc_valid = 1'b0;
        #1;
        check_eq("t2_dup_no_mark", mark_valid, 0);
        check_eq("t2_first_err", done_err, 0);
        tick();
        check_eq("t2_done_valid", done_valid, 1);
        check_eq("t2_dup_err", done_err, 1);
        check_eq("t2_count", count, 1);
        check_eq("t2_sticky", err_sticky, 1);

        // Alloc then release of the same tag, back-to-back
        do_reset();
        alloc_valid = 1'b1; alloc_tag = 8'h05;
        tick();
        alloc_valid = 1'b0;
        rel_valid = 1'b1; rel_tag = 8'h05;
        tick();
        rel_valid = 1'b0;
        #1 check_eq("t2b_rel_mark_inv", mark_invalid, 1);
        tick();
        check_eq("t2b_rel_err", {done_valid, done_op, done_err}, 3'b110);
        check_eq("t2b_count", count, 0);

        // Release of unknown tag with empty CAM
        do_reset();
        rel_valid = 1'b1; rel_tag = 8'h33;
        #1 check_eq("t3_rel_ready", rel_ready, 1);
        tick();
        rel_valid = 1'b0;
        #1;
        check_eq("t3_no_mark_inv", mark_invalid, 0);
        check_eq("t3_cam_tag", cam_tag_w, 8'h33);
        tick();
        check_eq("t3_done", {done_valid, done_op, done_err}, 3'b111);
        check_eq("t3_count", count, 0);
        check_eq("t3_sticky", err_sticky, 1);

        // Full boundary with a concurrent release
        do_reset();
        for (int t = 1; t <= 4; t++) begin
            alloc_valid = 1'b1; alloc_tag = N'(t);
            #1 check_eq("t4_fill_ready", alloc_ready, 1);
            tick();
        end
        alloc_tag = 8'h05;
        rel_valid = 1'b1; rel_tag = 8'h02;
        #1;
        check_eq("t4_alloc_blocked", alloc_ready, 0);
        check_eq("t4_rel_open", rel_ready, 1);
        tick();
        rel_valid = 1'b0;
        #1;
        check_eq("t4_count_full", count, 4);
        check_eq("t4_alloc_still_blocked", alloc_ready, 0);
        tick();
        check_eq("t4_count_after_rel", count, 3);
        check_eq("t4_alloc_reopen", alloc_ready, 1);
        tick();
        alloc_valid = 1'b0;
        tick();
        check_eq("t4_final_count", count, 4);
        check_eq("t4_sticky", err_sticky, 0);

        // Both channels valid: alloc first, then strict alternation
        do_reset();
        alloc_valid = 1'b1; alloc_tag = 8'h10;
        rel_valid   = 1'b1; rel_tag   = 8'h20;
        for (int k = 0; k < 4; k++) begin
            #1;
            check_eq("t5_alloc_grant", alloc_ready, (k % 2 == 0) ? 1 : 0);
            check_eq("t5_rel_grant", rel_ready, (k % 2 == 1) ? 1 : 0);
            if (alloc_ready) alloc_tag = alloc_tag + 1'b1;
            if (rel_ready)   rel_tag   = rel_tag + 1'b1;
            tick();
        end
        alloc_valid = 1'b0;
        rel_valid   = 1'b0;
        tick();
        tick();
        check_eq("t5_count", count, 2);

        // Async reset with a command pending
        do_reset();
        alloc_valid = 1'b1; alloc_tag = 8'h07;
        tick();
        alloc_valid = 1'b0;
        #1 check_eq("t6_pending_mark", mark_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("t6_rst_mark", mark_valid, 0);
        check_eq("t6_rst_cam_tag", cam_tag_w, 0);
        check_eq("t6_rst_count", count, 0);
        check_eq("t6_rst_done", done_valid, 0);
        check_eq("t6_rst_readies", {alloc_ready, rel_ready}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_eq("t6_no_done", done_valid, 0);
        end
        check_eq("t6_count", count, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_cam_tag_sequencer
